// File: rtl/pkt_width_upsizer.sv
// Packs RATIO input words into one wide beat with per-packet length/bad tracking,
// buffered in a FWFT FIFO. Optional protocol checking: PKT_UPSIZER_PROTO_CHECK_EN.
module pkt_width_upsizer #(
    parameter  int INPUT_WIDTH  = 32,
    parameter  int RATIO        = 2,
    parameter  int FIFO_DEPTH   = 8,
    localparam int OUTPUT_WIDTH = INPUT_WIDTH * RATIO,
    localparam int IN_BYTES     = INPUT_WIDTH / 8,
    localparam int OUT_BYTES    = OUTPUT_WIDTH / 8,
    localparam int RW           = $clog2(IN_BYTES),
    localparam int BW           = $clog2(OUT_BYTES) + 1,
    localparam int LVW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    iclk,
    input  logic                    irst,
    input  logic                    ivalid,
    input  logic                    isop,
    input  logic                    ieop,
    input  logic [RW-1:0]           iresidual,
    input  logic [INPUT_WIDTH-1:0]  idata,
    input  logic                    ibad,
    input  logic                    iclr_err,
    output logic                    ovalid,
    input  logic                    oready,
    output logic                    osop,
    output logic                    oeop,
    output logic [OUTPUT_WIDTH-1:0] odata,
    output logic [BW-1:0]           obytes,
    output logic [13:0]             oplen,
    output logic                    obad,
    output logic [LVW-1:0]          ofifo_level,
    output logic                    ocpu_interrupt
);

`ifdef PKT_UPSIZER_PROTO_CHECK_EN
    localparam bit PROTO = 1'b1;
`else
    localparam bit PROTO = 1'b0;
`endif
    localparam int LW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [LW-1:0]           r_lane;
    logic [OUTPUT_WIDTH-1:0] r_acc;
    logic                    r_in_pkt;
    logic [13:0]             r_len;
    logic                    r_bad;
    logic                    r_beat_sop;

    logic                    w_start, w_flush, w_orphan, w_take, w_push1;
    logic [LW-1:0]           w_lane;
    logic [OUTPUT_WIDTH-1:0] w_beat;
    logic [BW-1:0]           w_wbytes, w_bytes1, w_bytes0;
    logic [14:0]             w_len_sum;
    logic [13:0]             w_len_next;
    logic                    w_bad_next;

    // Assembler next-state: lane placement, push decision, byte and length accounting
    always_comb begin
        w_start    = ivalid & isop;
        w_flush    = PROTO & ivalid & isop & r_in_pkt;
        w_orphan   = ivalid & ~isop & ~r_in_pkt;
        w_take     = ivalid & ~(PROTO & w_orphan);
        w_lane     = w_start ? '0 : r_lane;
        w_beat     = w_start ? '0 : r_acc;
        w_beat[OUTPUT_WIDTH-1-int'(w_lane)*INPUT_WIDTH -: INPUT_WIDTH] = idata;
        w_push1    = w_take & ((int'(w_lane) == RATIO - 1) | ieop);
        w_wbytes   = (ieop && (iresidual != '0)) ? BW'(iresidual) : BW'(IN_BYTES);
        w_bytes1   = BW'(w_lane) * BW'(IN_BYTES) + w_wbytes;
        w_bytes0   = BW'(r_lane) * BW'(IN_BYTES);
        w_len_sum  = {1'b0, (w_start ? 14'd0 : r_len)} + 15'(w_wbytes);
        w_len_next = w_len_sum[14] ? 14'h3FFF : w_len_sum[13:0];
        w_bad_next = (w_start ? 1'b0 : r_bad) | ibad;
    end

    // Assembler state
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_lane     <= '0;
            r_acc      <= '0;
            r_in_pkt   <= 1'b0;
            r_len      <= 14'd0;
            r_bad      <= 1'b0;
            r_beat_sop <= 1'b0;
        end else if (w_take) begin
            r_lane     <= w_push1 ? '0 : w_lane + LW'(1);
            r_acc      <= w_push1 ? '0 : w_beat;
            r_beat_sop <= w_push1 ? 1'b0 : (w_start | r_beat_sop);
            r_len      <= w_len_next;
            r_bad      <= w_bad_next;
            r_in_pkt   <= ieop ? 1'b0 : (w_start | r_in_pkt);
        end
    end

    logic [OUTPUT_WIDTH-1:0] r_mem_data  [FIFO_DEPTH];
    logic                    r_mem_sop   [FIFO_DEPTH];
    logic                    r_mem_eop   [FIFO_DEPTH];
    logic [BW-1:0]           r_mem_bytes [FIFO_DEPTH];
    logic [13:0]             r_mem_plen  [FIFO_DEPTH];
    logic                    r_mem_bad   [FIFO_DEPTH];
    logic [AW-1:0]           r_wptr, r_rptr;
    logic [LVW-1:0]          r_level;
    logic                    r_err_ovf, r_err_sop_in_pkt, r_err_no_sop;

    logic                    w_pop, w_acc0, w_acc1, w_ovf;
    logic [LVW:0]            w_space;
    logic [AW-1:0]           w_wptr1;

    // A protocol flush and the new word's beat can both land in one cycle; flush goes first
    always_comb begin
        w_pop   = (r_level != '0) & oready;
        w_space = (LVW+1)'(FIFO_DEPTH) - {1'b0, r_level} + (LVW+1)'(w_pop);
        w_acc0  = w_flush & (w_space >= (LVW+1)'(1));
        w_acc1  = w_push1 & (w_space >= ((LVW+1)'(1) + (LVW+1)'(w_acc0)));
        w_ovf   = (w_flush & ~w_acc0) | (w_push1 & ~w_acc1);
        w_wptr1 = r_wptr + AW'(w_acc0);
    end

    // FIFO storage
    always_ff @(posedge iclk) begin
        if (w_acc0) begin
            r_mem_data[r_wptr]  <= r_acc;
            r_mem_sop[r_wptr]   <= r_beat_sop;
            r_mem_eop[r_wptr]   <= 1'b1;
            r_mem_bytes[r_wptr] <= w_bytes0;
            r_mem_plen[r_wptr]  <= r_len;
            r_mem_bad[r_wptr]   <= 1'b1;
        end
        if (w_acc1) begin
            r_mem_data[w_wptr1]  <= w_beat;
            r_mem_sop[w_wptr1]   <= w_start | r_beat_sop;
            r_mem_eop[w_wptr1]   <= ieop;
            r_mem_bytes[w_wptr1] <= w_bytes1;
            r_mem_plen[w_wptr1]  <= ieop ? w_len_next : 14'd0;
            r_mem_bad[w_wptr1]   <= ieop ? w_bad_next : 1'b0;
        end
    end

    // FIFO pointers, occupancy and sticky errors (a new error beats a same-cycle clear)
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_wptr           <= '0;
            r_rptr           <= '0;
            r_level          <= '0;
            r_err_ovf        <= 1'b0;
            r_err_sop_in_pkt <= 1'b0;
            r_err_no_sop     <= 1'b0;
        end else begin
            r_wptr           <= r_wptr + AW'(w_acc0) + AW'(w_acc1);
            r_rptr           <= r_rptr + AW'(w_pop);
            r_level          <= r_level + LVW'(w_acc0) + LVW'(w_acc1) - LVW'(w_pop);
            r_err_ovf        <= w_ovf | (r_err_ovf & ~iclr_err);
            r_err_sop_in_pkt <= w_flush | (r_err_sop_in_pkt & ~iclr_err);
            r_err_no_sop     <= (PROTO & w_orphan) | (r_err_no_sop & ~iclr_err);
        end
    end

    assign ovalid         = (r_level != '0);
    assign osop           = ovalid ? r_mem_sop[r_rptr]   : 1'b0;
    assign oeop           = ovalid ? r_mem_eop[r_rptr]   : 1'b0;
    assign odata          = ovalid ? r_mem_data[r_rptr]  : '0;
    assign obytes         = ovalid ? r_mem_bytes[r_rptr] : '0;
    assign oplen          = ovalid ? r_mem_plen[r_rptr]  : 14'd0;
    assign obad           = ovalid ? r_mem_bad[r_rptr]   : 1'b0;
    assign ofifo_level    = r_level;
    assign ocpu_interrupt = r_err_ovf | r_err_sop_in_pkt | r_err_no_sop;

endmodule

// File: tb/tb_pkt_width_upsizer.sv
// Directed self-checking bench for pkt_width_upsizer (INPUT_WIDTH=32, RATIO=4, FIFO_DEPTH=8).
module tb_pkt_width_upsizer;
    logic         iclk = 1'b0;
    logic         irst, ivalid, isop, ieop, ibad, iclr_err, oready;
    logic [1:0]   iresidual;
    logic [31:0]  idata;
    logic         ovalid, osop, oeop, obad, ocpu_interrupt;
    logic [127:0] odata;
    logic [4:0]   obytes;
    logic [13:0]  oplen;
    logic [3:0]   ofifo_level;

    typedef struct {
        logic [127:0] data;
        logic         sop;
        logic         eop;
        logic [4:0]   bytes;
        logic [13:0]  plen;
        logic         bad;
        int           cyc;
    } beat_t;

    beat_t q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;

    pkt_width_upsizer #(.INPUT_WIDTH(32), .RATIO(4), .FIFO_DEPTH(8)) dut (
        .iclk(iclk), .irst(irst), .ivalid(ivalid), .isop(isop), .ieop(ieop),
        .iresidual(iresidual), .idata(idata), .ibad(ibad), .iclr_err(iclr_err),
        .ovalid(ovalid), .oready(oready), .osop(osop), .oeop(oeop), .odata(odata),
        .obytes(obytes), .oplen(oplen), .obad(obad), .ofifo_level(ofifo_level),
        .ocpu_interrupt(ocpu_interrupt)
    );

    always #5 iclk = ~iclk;

    always @(posedge iclk) cyc <= cyc + 1;

    always @(negedge iclk) begin
        if (ovalid && oready) begin
            beat_t b;
            b.data = odata; b.sop = osop; b.eop = oeop; b.bytes = obytes;
            b.plen = oplen; b.bad = obad; b.cyc = cyc;
            q.push_back(b);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic send(input logic s, input logic e, input logic [1:0] res,
                        input logic [31:0] d, input logic b);
        ivalid = 1'b1; isop = s; ieop = e; iresidual = res; idata = d; ibad = b;
        tick(1);
        ivalid = 1'b0; isop = 1'b0; ieop = 1'b0; iresidual = 2'd0; ibad = 1'b0;
    endtask

    task automatic test_reset();
        ivalid = 1'b0; isop = 1'b0; ieop = 1'b0; ibad = 1'b0; iclr_err = 1'b0;
        iresidual = 2'd0; idata = 32'd0; oready = 1'b1; irst = 1'b1;
        tick(3);
        irst = 1'b0;
        tick(1);
        checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_ovalid: got %b want 0", ovalid); end
        checks++; if (ofifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", ofifo_level); end
        checks++; if (ocpu_interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", ocpu_interrupt); end
        checks++; if (odata !== 128'd0 || obytes !== 5'd0 || oplen !== 14'd0) begin errors++; $display("FAIL reset_fields: got data=%h bytes=%0d plen=%0d want 0", odata, obytes, oplen); end
    endtask

    task automatic test_basic();
        int s0;
        q.delete();
        oready = 1'b1;
        s0 = cyc;
        for (int i = 0; i < 8; i++) send(i == 0, i == 7, 2'd0, 32'hA000_0000 + i, 1'b0);
        tick(4);
        checks++; if (q.size() !== 2) begin errors++; $display("FAIL basic_count: got %0d want 2", q.size()); end
        if (q.size() >= 2) begin
            checks++; if (q[0].sop !== 1'b1 || q[0].eop !== 1'b0) begin errors++; $display("FAIL basic_b1_flags: got sop=%b eop=%b want sop=1 eop=0", q[0].sop, q[0].eop); end
            checks++; if (q[0].bytes !== 5'd16) begin errors++; $display("FAIL basic_b1_bytes: got %0d want 16", q[0].bytes); end
            checks++; if (q[0].data !== 128'hA0000000_A0000001_A0000002_A0000003) begin errors++; $display("FAIL basic_b1_data: got %h want a0000000a0000001a0000002a0000003", q[0].data); end
            checks++; if (q[0].cyc - s0 !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", q[0].cyc - s0); end
            checks++; if (q[1].sop !== 1'b0 || q[1].eop !== 1'b1 || q[1].bytes !== 5'd16) begin errors++; $display("FAIL basic_b2_flags: got sop=%b eop=%b bytes=%0d want 0 1 16", q[1].sop, q[1].eop, q[1].bytes); end
            checks++; if (q[1].plen !== 14'd32 || q[1].bad !== 1'b0) begin errors++; $display("FAIL basic_b2_plen: got plen=%0d bad=%b want 32 0", q[1].plen, q[1].bad); end
            checks++; if (q[1].data !== 128'hA0000004_A0000005_A0000006_A0000007) begin errors++; $display("FAIL basic_b2_data: got %h want a0000004a0000005a0000006a0000007", q[1].data); end
        end
    endtask

    task automatic test_residual();
        q.delete();
        for (int i = 0; i < 5; i++) send(i == 0, i == 4, (i == 4) ? 2'd3 : 2'd0, 32'hB000_0000 + i, 1'b0);
        tick(4);
        checks++; if (q.size() !== 2) begin errors++; $display("FAIL resid_count: got %0d want 2", q.size()); end
        if (q.size() >= 2) begin
            checks++; if (q[0].bytes !== 5'd16 || q[0].plen !== 14'd0) begin errors++; $display("FAIL resid_b1: got bytes=%0d plen=%0d want 16 0", q[0].bytes, q[0].plen); end
            checks++; if (q[1].bytes !== 5'd3 || q[1].eop !== 1'b1) begin errors++; $display("FAIL resid_b2_bytes: got bytes=%0d eop=%b want 3 1", q[1].bytes, q[1].eop); end
            checks++; if (q[1].data !== {32'hB000_0004, 96'd0}) begin errors++; $display("FAIL resid_b2_data: got %h want b0000004 followed by zeros", q[1].data); end
            checks++; if (q[1].plen !== 14'd19) begin errors++; $display("FAIL resid_b2_plen: got %0d want 19", q[1].plen); end
        end
    endtask

    task automatic test_single();
        q.delete();
        send(1'b1, 1'b1, 2'd2, 32'hC0C0_C0C0, 1'b0);
        tick(3);
        checks++; if (q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", q.size()); end
        if (q.size() >= 1) begin
            checks++; if (q[0].sop !== 1'b1 || q[0].eop !== 1'b1) begin errors++; $display("FAIL single_flags: got sop=%b eop=%b want 1 1", q[0].sop, q[0].eop); end
            checks++; if (q[0].bytes !== 5'd2 || q[0].plen !== 14'd2) begin errors++; $display("FAIL single_len: got bytes=%0d plen=%0d want 2 2", q[0].bytes, q[0].plen); end
            checks++; if (q[0].data !== {32'hC0C0_C0C0, 96'd0}) begin errors++; $display("FAIL single_data: got %h want c0c0c0c0 followed by zeros", q[0].data); end
        end
    endtask

    task automatic test_back_to_back();
        q.delete();
        send(1'b1, 1'b1, 2'd0, 32'h1111_1111, 1'b0);
        send(1'b1, 1'b1, 2'd1, 32'h2222_2222, 1'b0);
        tick(3);
        checks++; if (q.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", q.size()); end
        if (q.size() >= 2) begin
            checks++; if (q[0].bytes !== 5'd4 || q[0].plen !== 14'd4) begin errors++; $display("FAIL b2b_p1: got bytes=%0d plen=%0d want 4 4", q[0].bytes, q[0].plen); end
            checks++; if (q[1].bytes !== 5'd1 || q[1].plen !== 14'd1) begin errors++; $display("FAIL b2b_p2: got bytes=%0d plen=%0d want 1 1", q[1].bytes, q[1].plen); end
            checks++; if (q[1].cyc - q[0].cyc !== 1) begin errors++; $display("FAIL b2b_spacing: got %0d want 1", q[1].cyc - q[0].cyc); end
        end
    endtask

    task automatic test_overflow();
        q.delete();
        oready = 1'b0;
        for (int i = 0; i < 40; i++) send(i == 0, i == 39, 2'd0, 32'hD000_0000 + i, 1'b0);
        tick(2);
        checks++; if (ofifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d want 8", ofifo_level); end
        checks++; if (ocpu_interrupt !== 1'b1) begin errors++; $display("FAIL ovf_irq: got %b want 1", ocpu_interrupt); end
        oready = 1'b1;
        tick(12);
        checks++; if (q.size() !== 8) begin errors++; $display("FAIL ovf_drained: got %0d want 8", q.size()); end
        if (q.size() >= 8) begin
            checks++; if (q[0].sop !== 1'b1 || q[0].data !== 128'hD0000000_D0000001_D0000002_D0000003) begin errors++; $display("FAIL ovf_first: got sop=%b data=%h want sop=1 d0000000..d0000003", q[0].sop, q[0].data); end
            checks++; if (q[7].eop !== 1'b0 || q[7].data !== 128'hD000001C_D000001D_D000001E_D000001F) begin errors++; $display("FAIL ovf_last: got eop=%b data=%h want eop=0 d000001c..d000001f", q[7].eop, q[7].data); end
        end
        checks++; if (ofifo_level !== 4'd0) begin errors++; $display("FAIL ovf_empty: got %0d want 0", ofifo_level); end
        iclr_err = 1'b1;
        tick(1);
        iclr_err = 1'b0;
        checks++; if (ocpu_interrupt !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ocpu_interrupt); end
    endtask

    task automatic test_bad();
        q.delete();
        for (int i = 0; i < 8; i++) send(i == 0, i == 7, 2'd0, 32'hE000_0000 + i, i == 2);
        tick(4);
        checks++; if (q.size() !== 2) begin errors++; $display("FAIL bad_count: got %0d want 2", q.size()); end
        if (q.size() >= 2) begin
            checks++; if (q[0].bad !== 1'b0) begin errors++; $display("FAIL bad_b1: got %b want 0", q[0].bad); end
            checks++; if (q[1].bad !== 1'b1 || q[1].plen !== 14'd32) begin errors++; $display("FAIL bad_b2: got bad=%b plen=%0d want 1 32", q[1].bad, q[1].plen); end
            checks++; if (q[0].data !== 128'hE0000000_E0000001_E0000002_E0000003) begin errors++; $display("FAIL bad_data: got %h want e0000000..e0000003", q[0].data); end
        end
    endtask

    task automatic test_sop_mid();
        q.delete();
        send(1'b1, 1'b0, 2'd0, 32'hF000_0000, 1'b0);
        send(1'b0, 1'b0, 2'd0, 32'hF000_0001, 1'b0);
        for (int i = 0; i < 4; i++) send(i == 0, i == 3, 2'd0, 32'h9000_0000 + i, 1'b0);
        tick(4);
`ifdef PKT_UPSIZER_PROTO_CHECK_EN
        checks++; if (q.size() !== 2) begin errors++; $display("FAIL sopmid_count: got %0d want 2", q.size()); end
        if (q.size() >= 2) begin
            checks++; if (q[0].eop !== 1'b1 || q[0].bad !== 1'b1 || q[0].bytes !== 5'd8) begin errors++; $display("FAIL sopmid_flush: got eop=%b bad=%b bytes=%0d want 1 1 8", q[0].eop, q[0].bad, q[0].bytes); end
            checks++; if (q[1].sop !== 1'b1 || q[1].eop !== 1'b1 || q[1].plen !== 14'd16) begin errors++; $display("FAIL sopmid_new: got sop=%b eop=%b plen=%0d want 1 1 16", q[1].sop, q[1].eop, q[1].plen); end
        end
        checks++; if (ocpu_interrupt !== 1'b1) begin errors++; $display("FAIL sopmid_irq: got %b want 1", ocpu_interrupt); end
        iclr_err = 1'b1;
        tick(1);
        iclr_err = 1'b0;
`else
        checks++; if (q.size() !== 1) begin errors++; $display("FAIL sopmid_count: got %0d want 1", q.size()); end
        if (q.size() >= 1) begin
            checks++; if (q[0].sop !== 1'b1 || q[0].eop !== 1'b1 || q[0].bytes !== 5'd16 || q[0].plen !== 14'd16 || q[0].bad !== 1'b0) begin errors++; $display("FAIL sopmid_new: got sop=%b eop=%b bytes=%0d plen=%0d bad=%b want 1 1 16 16 0", q[0].sop, q[0].eop, q[0].bytes, q[0].plen, q[0].bad); end
            checks++; if (q[0].data !== 128'h90000000_90000001_90000002_90000003) begin errors++; $display("FAIL sopmid_data: got %h want 90000000..90000003", q[0].data); end
        end
        checks++; if (ocpu_interrupt !== 1'b0) begin errors++; $display("FAIL sopmid_irq: got %b want 0", ocpu_interrupt); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_residual();
        test_single();
        test_back_to_back();
        test_bad();
        test_overflow();
        test_sop_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
